ab_seq_gen: RTL and testbench
=============================

AB_SEQ_GEN -- requirements
Module: ab_seq_gen

Interface
REQ-001 Parameter CNT_W, default 8, width of pair count and result counters.
REQ-002 Parameter GAP_W, default 4, width of inter-pair idle gap.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low.
REQ-005 start_valid  input  1  request to run a sequence.
REQ-006 start_ready  output  1  high only in IDLE; start accepted when start_valid && start_ready.
REQ-007 num_pairs  input  CNT_W  number of A-then-B pairs; sampled on start accept.
REQ-008 gap  input  GAP_W  idle cycles between pairs; sampled on start accept.
REQ-009 abort  input  1  terminate a running sequence.
REQ-010 a_out  output  1  A stimulus to the downstream A/B detector.
REQ-011 b_out  output  1  B stimulus to the downstream A/B detector.
REQ-012 q_in  input  1  detector's registered hit pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at end of sequence (normal, aborted or zero-length).
REQ-015 aborted  output  1  valid with done; high if sequence ended by abort.
REQ-016 hit_cnt  output  CNT_W  pairs for which q_in was seen in the check window.
REQ-017 miss_cnt  output  CNT_W  pairs for which q_in was not seen in the check window.
REQ-018 spurious  output  1  sticky; set when q_in is high outside the check window.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, DRIVE_A, DRIVE_B, CHECK, GAP.
REQ-021 IDLE: a_out=b_out=0; on start accept with num_pairs!=0, latch num_pairs and gap, clear hit_cnt, miss_cnt and spurious, then go DRIVE_A.
REQ-022 Start accept with num_pairs==0 SHALL clear counters and spurious, pulse done (aborted=0) the next cycle, and stay IDLE.
REQ-023 DRIVE_A: a_out=1, b_out=0 for exactly one cycle, then DRIVE_B.
REQ-024 DRIVE_B: a_out=0, b_out=1 for exactly one cycle, then CHECK.
REQ-025 CHECK: a_out=b_out=0 for one cycle; q_in=1 increments hit_cnt, q_in=0 increments miss_cnt; then decrement the remaining-pair count.
REQ-026 After CHECK: remaining count 0 -> IDLE with done=1, aborted=0 for one cycle; else gap==0 -> DRIVE_A; else GAP.
REQ-027 GAP: a_out=b_out=0 for exactly the latched gap cycles, then DRIVE_A.
REQ-028 CHECK SHALL occur two cycles after DRIVE_A, matching a detector that registers A, then B, then Q.
REQ-029 q_in=1 in IDLE, DRIVE_A, DRIVE_B or GAP SHALL set spurious; it SHALL NOT change hit_cnt or miss_cnt.
REQ-030 hit_cnt + miss_cnt SHALL equal the number of completed CHECK cycles; no overflow is possible because the total is bounded by num_pairs.
REQ-031 abort in any non-IDLE state SHALL move to IDLE next cycle, drive a_out=b_out=0, and pulse done with aborted=1.
REQ-032 If abort coincides with CHECK, the CHECK result SHALL still be counted.
REQ-033 abort in IDLE SHALL be ignored.
REQ-034 abort in the same cycle as a start accept SHALL be ignored.
REQ-035 Counters and spurious SHALL hold their final values in IDLE until the next start accept.

Reset
REQ-036 While reset=0 at a clock edge: state=IDLE; a_out, b_out, busy, done, aborted, spurious=0; hit_cnt=miss_cnt=0; start_ready=1 after release.
REQ-037 Reset SHALL take priority over abort, start and q_in, including mid-sequence; no done pulse is produced on reset.

Verification
REQ-038 num_pairs=3, gap=0, q_in looped through the detector -> a_out pattern 1,0,0,1,0,0,1,0,0; done at cycle 10 after accept; hit_cnt=3, miss_cnt=0, spurious=0.
REQ-039 num_pairs=2, gap=2, q_in tied 0 -> each pair takes 5 cycles; hit_cnt=0, miss_cnt=2, done with aborted=0.
REQ-040 num_pairs=5, abort asserted during the second DRIVE_B -> IDLE next cycle; done=1 with aborted=1; hit_cnt=1 with the detector looped back; a_out and b_out low.
REQ-041 num_pairs=0 -> no a_out/b_out activity; done one cycle after accept; counters 0; busy stays 0.
REQ-042 num_pairs=1, q_in forced 1 during DRIVE_A -> spurious=1; q_in=0 in CHECK gives miss_cnt=1.
REQ-043 reset=0 during GAP of num_pairs=4 -> all outputs reset values next edge; no done; a new start is accepted after release.

Source files
------------

// File: rtl/ab_seq_gen.sv
// A-then-B stimulus sequencer: drives pairs into an A/B detector, scores its hit pulse per pair.
// Outputs registered (1 cycle from state change); start is taken only in IDLE via start_ready, abort ends a run next cycle.
module ab_seq_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             a_out,
  output logic             b_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             spurious
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE_A = 3'd1;
  localparam logic [2:0] S_DRIVE_B = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] rem_q,     rem_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] hit_q,     hit_d;
  logic [CNT_W-1:0] miss_q,    miss_d;
  logic             spur_q,    spur_d;
  logic             done_q,    done_d;
  logic             abrt_q,    abrt_d;
  logic             a_q,       a_d;
  logic             b_q,       b_d;
  logic             busy_q,    busy_d;
  logic             ready_q,   ready_d;
  logic             start_acc;

  assign start_acc = start_valid && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    spur_d    = spur_q;
    done_d    = 1'b0;
    abrt_d    = 1'b0;

    // Only the CHECK cycle is a legitimate window for the detector's pulse.
    if (q_in && (state_q != S_CHECK)) begin
      spur_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          hit_d  = '0;
          miss_d = '0;
          spur_d = 1'b0;
          if (num_pairs == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d     = num_pairs;
            gap_len_d = gap;
            state_d   = S_DRIVE_A;
          end
        end
      end
      S_DRIVE_A: state_d = S_DRIVE_B;
      S_DRIVE_B: state_d = S_CHECK;
      S_CHECK: begin
        if (q_in) begin
          hit_d = hit_q + CNT_ONE;
        end else begin
          miss_d = miss_q + CNT_ONE;
        end
        rem_d = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_len_q == '0) begin
          state_d = S_DRIVE_A;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = gap_len_q;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_ONE) begin
          state_d = S_DRIVE_A;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the next state but leaves any CHECK result above intact.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      abrt_d  = 1'b1;
    end

    a_d     = (state_d == S_DRIVE_A);
    b_d     = (state_d == S_DRIVE_B);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      spur_q    <= 1'b0;
      done_q    <= 1'b0;
      abrt_q    <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      spur_q    <= spur_d;
      done_q    <= done_d;
      abrt_q    <= abrt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign start_ready = ready_q;
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = abrt_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign spurious    = spur_q;

  a_b_exclusive: assert property (@(posedge clk) disable iff (!reset) !(a_q && b_q));
  done_when_idle: assert property (@(posedge clk) disable iff (!reset) done_q |-> (!busy_q && ready_q));
  aborted_with_done: assert property (@(posedge clk) disable iff (!reset) abrt_q |-> done_q);

endmodule

// File: tb/tb_ab_seq_gen.sv
// Directed bench for ab_seq_gen with a registered A->B->Q detector model in the loopback path.
module tb_ab_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] num_pairs;
  logic [3:0] gap;
  logic       abort;
  logic       a_out, b_out, q_in;
  logic       busy, done, aborted, spurious;
  logic [7:0] hit_cnt, miss_cnt;

  logic loop_en, q_drv, a_seen, q_det;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ab_seq_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .num_pairs(num_pairs), .gap(gap), .abort(abort), .a_out(a_out), .b_out(b_out),
    .q_in(q_in), .busy(busy), .done(done), .aborted(aborted), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .spurious(spurious)
  );

  always @(posedge clk) begin
    if (!reset) begin
      a_seen <= 1'b0;
      q_det  <= 1'b0;
    end else begin
      a_seen <= a_out;
      q_det  <= a_seen & b_out;
    end
  end

  assign q_in = loop_en ? q_det : q_drv;

  typedef struct {
    logic [7:0]  n;
    logic [3:0]  g;
    bit          loop;
    int          done_at;
    logic [7:0]  hit;
    logic [7:0]  miss;
    logic [31:0] a_m;
    logic [31:0] b_m;
    logic [31:0] busy_m;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c;
    bit found;
    logic [31:0] am, bm, bsm;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), start_ready, 1);
    loop_en = v.loop; q_drv = 1'b0;
    num_pairs = v.n; gap = v.g; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    c = 1; found = 0; am = '0; bm = '0; bsm = '0;
    while (c <= 40 && !found) begin
      if (c <= 32) begin
        am[c-1] = a_out; bm[c-1] = b_out; bsm[c-1] = busy;
      end
      if (done) begin
        found = 1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    chk($sformatf("v%0d_done_seen", idx), found, 1);
    if (found) begin
      chk($sformatf("v%0d_done_cycle", idx), c, v.done_at);
      chk($sformatf("v%0d_aborted", idx), aborted, 0);
      chk($sformatf("v%0d_hit", idx), hit_cnt, v.hit);
      chk($sformatf("v%0d_miss", idx), miss_cnt, v.miss);
      chk($sformatf("v%0d_spurious", idx), spurious, 0);
      chk($sformatf("v%0d_a_pattern", idx), am, v.a_m);
      chk($sformatf("v%0d_b_pattern", idx), bm, v.b_m);
      chk($sformatf("v%0d_busy_pattern", idx), bsm, v.busy_m);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", idx), done, 0);
      @(negedge clk);
      chk($sformatf("v%0d_hold", idx), {hit_cnt, miss_cnt}, {v.hit, v.miss});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           n     g     loop done hit   miss  a_m           b_m           busy_m
    tbl[0] = '{8'd3, 4'd0,  1, 10, 8'd3, 8'd0, 32'h49,       32'h92,       32'h1FF};
    tbl[1] = '{8'd2, 4'd2,  0, 9,  8'd0, 8'd2, 32'h21,       32'h42,       32'hFF};
    tbl[2] = '{8'd1, 4'd3,  1, 4,  8'd1, 8'd0, 32'h1,        32'h2,        32'h7};
    tbl[3] = '{8'd2, 4'd1,  1, 8,  8'd2, 8'd0, 32'h11,       32'h22,       32'h7F};
    tbl[4] = '{8'd0, 4'd5,  1, 1,  8'd0, 8'd0, 32'h0,        32'h0,        32'h0};
    tbl[5] = '{8'd4, 4'd0,  0, 13, 8'd0, 8'd4, 32'h249,      32'h492,      32'hFFF};
    tbl[6] = '{8'd2, 4'd15, 0, 22, 8'd0, 8'd2, 32'h40001,    32'h80002,    32'h1FFFFF};

    reset = 1'b0; start_valid = 1'b0; abort = 1'b0; q_drv = 1'b0; loop_en = 1'b1;
    num_pairs = '0; gap = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a_out, b_out, busy, done, aborted, spurious, hit_cnt, miss_cnt}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", start_ready, 1);
    chk("reset_release_outputs", {a_out, b_out, busy, done, aborted, spurious, hit_cnt, miss_cnt}, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
    end

    // Abort in the second DRIVE_B: first pair already scored.
    @(negedge clk);
    loop_en = 1'b1; num_pairs = 8'd5; gap = 4'd0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abB_in_drive_b", {a_out, b_out, busy}, 3'b011);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abB_done_aborted", {done, aborted}, 2'b11);
    chk("abB_outputs_low", {a_out, b_out, busy, start_ready}, 4'b0001);
    chk("abB_counts", {hit_cnt, miss_cnt}, {8'd1, 8'd0});
    @(negedge clk);
    chk("abB_done_pulse", {done, aborted}, 2'b00);
    chk("abB_late_q_spurious", spurious, 1);

    // Abort coinciding with CHECK: that pair still counts; accept cleared spurious.
    loop_en = 1'b1; num_pairs = 8'd3; gap = 4'd0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abC_done_aborted", {done, aborted, busy}, 3'b110);
    chk("abC_counts_spur", {hit_cnt, miss_cnt, 7'd0, spurious}, {8'd1, 8'd0, 8'd0});

    // Abort while idle is ignored.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_ignored", {done, aborted, busy, start_ready}, 4'b0001);

    // Abort together with start accept is ignored.
    loop_en = 1'b1; num_pairs = 8'd1; gap = 4'd0; start_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; abort = 1'b0;
    chk("abS_started", {a_out, busy, done}, 3'b110);
    repeat (3) @(negedge clk);
    chk("abS_finished", {done, aborted, hit_cnt, miss_cnt}, {2'b10, 8'd1, 8'd0});

    // q_in high during DRIVE_A is spurious, then a miss at CHECK.
    @(negedge clk);
    loop_en = 1'b0; q_drv = 1'b0; num_pairs = 8'd1; gap = 4'd0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    q_drv = 1'b1;
    @(negedge clk);
    q_drv = 1'b0;
    chk("spur_set", {spurious, hit_cnt, miss_cnt}, {1'b1, 8'd0, 8'd0});
    repeat (2) @(negedge clk);
    chk("spur_done", {done, aborted, spurious, hit_cnt, miss_cnt}, {3'b101, 8'd0, 8'd1});

    // Reset in the middle of GAP: no done, clean restart afterwards.
    @(negedge clk);
    loop_en = 1'b1; num_pairs = 8'd4; gap = 4'd3; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstgap_in_gap", {a_out, b_out, busy, hit_cnt}, {3'b001, 8'd1});
    reset = 1'b0;
    @(negedge clk);
    chk("rstgap_outputs", {a_out, b_out, busy, done, aborted, spurious, hit_cnt, miss_cnt}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstgap_release", {start_ready, done, busy}, 3'b100);
    run_vec(tbl[2], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
